// File: rtl/match_controller.sv
// rtl/match_controller.sv - foosball match sequencer: serve/play/goal/over, scores and ball-speed select
// Every output is registered; speed_sel bypasses to ball_speed only until the first clock after reset.
module match_controller #(
   parameter int WIN_SCORE     = 7,
   parameter int SERVE_FRAMES  = 60,
   parameter int GOAL_FRAMES   = 120,
   parameter int HITS_PER_STEP = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_game,
   input  logic       frame_tick,
   input  logic       goal_p1,
   input  logic       goal_p2,
   input  logic       paddle_hit,
   input  logic [1:0] ball_speed,
   output logic       ball_reset,
   output logic       ball_enable,
   output logic       serve_dir,
   output logic [1:0] speed_sel,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      GOAL  = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam int FMAX = (SERVE_FRAMES > GOAL_FRAMES) ? SERVE_FRAMES : GOAL_FRAMES;
   localparam int FW   = $clog2(FMAX + 1);
   localparam int HW   = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;
   localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
   localparam logic [FW-1:0] GOAL_LAST  = FW'(GOAL_FRAMES - 1);
   localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_STEP - 1);
   localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

   logic start_meta, start_sync, start_prev, start_pulse;

   state_t        state, state_nxt;
   logic [FW-1:0] frame_cnt, frame_nxt;
   logic [HW-1:0] hit_cnt, hit_nxt;
   logic [1:0]    boost, boost_nxt;
   logic [3:0]    s1_nxt, s2_nxt;
   logic          dir_nxt;
   logic [1:0]    win_nxt;
   logic [2:0]    speed_sum;
   logic [1:0]    speed_nxt, speed_r;
   logic          running;

   // Two-flop synchronizer, then a registered rising-edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_meta  <= 1'b0;
         start_sync  <= 1'b0;
         start_prev  <= 1'b0;
         start_pulse <= 1'b0;
      end else begin
         start_meta  <= start_game;
         start_sync  <= start_meta;
         start_prev  <= start_sync;
         start_pulse <= start_sync & ~start_prev;
      end
   end

   always_comb begin
      state_nxt = state;
      frame_nxt = frame_cnt;
      hit_nxt   = hit_cnt;
      boost_nxt = boost;
      s1_nxt    = score1;
      s2_nxt    = score2;
      dir_nxt   = serve_dir;
      win_nxt   = winner;
      case (state)
         IDLE: if (start_pulse) state_nxt = SERVE;
         SERVE: if (frame_tick) begin
            if (frame_cnt == SERVE_LAST) state_nxt = PLAY;
            else                         frame_nxt = frame_cnt + 1'b1;
         end
         PLAY: begin
            if (goal_p1 && !goal_p2) begin
               s1_nxt  = score1 + 4'd1;
               dir_nxt = 1'b1;
               if (s1_nxt == WIN) begin
                  state_nxt = OVER;
                  win_nxt   = 2'b01;
               end else begin
                  state_nxt = GOAL;
                  hit_nxt   = '0;
                  boost_nxt = 2'd0;
               end
            end else if (goal_p2 && !goal_p1) begin
               s2_nxt  = score2 + 4'd1;
               dir_nxt = 1'b0;
               if (s2_nxt == WIN) begin
                  state_nxt = OVER;
                  win_nxt   = 2'b10;
               end else begin
                  state_nxt = GOAL;
                  hit_nxt   = '0;
                  boost_nxt = 2'd0;
               end
            end else if (paddle_hit && !goal_p1 && !goal_p2) begin
               if (hit_cnt == HIT_LAST) begin
                  hit_nxt = '0;
                  if (boost != 2'd3) boost_nxt = boost + 2'd1;
               end else begin
                  hit_nxt = hit_cnt + 1'b1;
               end
            end
         end
         GOAL: if (frame_tick) begin
            if (frame_cnt == GOAL_LAST) state_nxt = SERVE;
            else                        frame_nxt = frame_cnt + 1'b1;
         end
         OVER: if (start_pulse) begin
            state_nxt = SERVE;
            s1_nxt    = 4'd0;
            s2_nxt    = 4'd0;
            win_nxt   = 2'b00;
            dir_nxt   = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) frame_nxt = '0;
      speed_sum = {1'b0, ball_speed} + {1'b0, boost_nxt};
      speed_nxt = (speed_sum > 3'd3) ? 2'd3 : speed_sum[1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         frame_cnt   <= '0;
         hit_cnt     <= '0;
         boost       <= 2'd0;
         score1      <= 4'd0;
         score2      <= 4'd0;
         serve_dir   <= 1'b0;
         winner      <= 2'b00;
         game_over   <= 1'b0;
         ball_reset  <= 1'b1;
         ball_enable <= 1'b0;
         speed_r     <= 2'd0;
         running     <= 1'b0;
      end else begin
         state       <= state_nxt;
         frame_cnt   <= frame_nxt;
         hit_cnt     <= hit_nxt;
         boost       <= boost_nxt;
         score1      <= s1_nxt;
         score2      <= s2_nxt;
         serve_dir   <= dir_nxt;
         winner      <= win_nxt;
         game_over   <= (state_nxt == OVER);
         ball_reset  <= (state_nxt != PLAY);
         ball_enable <= (state_nxt == PLAY);
         speed_r     <= speed_nxt;
         running     <= 1'b1;
      end
   end

   // Until the first post-reset clock the base switch is shown directly (boost is zero then)
   assign speed_sel = running ? speed_r : ball_speed;
   assign state_o   = state;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - self-checking bench for match_controller
module tb_match_controller;

   localparam int WIN   = 7;
   localparam int SF    = 60;
   localparam int GF    = 120;
   localparam int HITS  = 4;

   logic       clk = 1'b0, reset = 1'b1;
   logic       start_game = 1'b0, frame_tick = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0, paddle_hit = 1'b0;
   logic [1:0] ball_speed = 2'd0;
   logic       ball_reset, ball_enable, serve_dir, game_over;
   logic [1:0] speed_sel, winner;
   logic [3:0] score1, score2;
   logic [2:0] state_o;

   int checks = 0, errors = 0;

   match_controller #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF), .GOAL_FRAMES(GF), .HITS_PER_STEP(HITS)) dut (
      .clk(clk), .reset(reset), .start_game(start_game), .frame_tick(frame_tick),
      .goal_p1(goal_p1), .goal_p2(goal_p2), .paddle_hit(paddle_hit), .ball_speed(ball_speed),
      .ball_reset(ball_reset), .ball_enable(ball_enable), .serve_dir(serve_dir), .speed_sel(speed_sel),
      .score1(score1), .score2(score2), .game_over(game_over), .winner(winner), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 serve, 2 play, 3 goal, 4 over
   int m_state, m_s1, m_s2, m_dir, m_win, m_ticks, m_hits, m_boost, m_speed;
   int hist[$];

   task automatic model_reset();
      m_state = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
      m_ticks = 0; m_hits = 0; m_boost = 0; m_speed = -1;
      hist = '{0, 0, 0, 0, 0};
   endtask

   task automatic model_edge();
      int old;
      bit press;
      hist.push_front(int'(start_game));
      void'(hist.pop_back());
      // a press shows up as a state change three edges after it is first sampled
      press = (hist[3] == 1) && (hist[4] == 0);
      old = m_state;
      case (m_state)
         0: if (press) m_state = 1;
         1: if (frame_tick) begin m_ticks++; if (m_ticks == SF) m_state = 2; end
         2: begin
            if (goal_p1 != goal_p2) begin
               if (goal_p1) begin
                  m_s1++; m_dir = 1;
                  if (m_s1 == WIN) begin m_state = 4; m_win = 1; end else m_state = 3;
               end else begin
                  m_s2++; m_dir = 0;
                  if (m_s2 == WIN) begin m_state = 4; m_win = 2; end else m_state = 3;
               end
               if (m_state == 3) begin m_hits = 0; m_boost = 0; end
            end else if (paddle_hit && !goal_p1) begin
               m_hits++;
               if (m_hits == HITS) begin m_hits = 0; m_boost = (m_boost < 3) ? m_boost + 1 : 3; end
            end
         end
         3: if (frame_tick) begin m_ticks++; if (m_ticks == GF) m_state = 1; end
         default: if (press) begin m_state = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; end
      endcase
      if (m_state != old) m_ticks = 0;
      m_speed = (int'(ball_speed) + m_boost > 3) ? 3 : int'(ball_speed) + m_boost;
   endtask

   task automatic check_all(input string name);
      logic [18:0] act, exp;
      logic [1:0]  spd;
      spd = (m_speed < 0) ? ball_speed : 2'(m_speed);
      exp = {3'(m_state), m_state != 2, m_state == 2, 1'(m_dir), spd, 4'(m_s1), 4'(m_s2),
             m_state == 4, 2'(m_win)};
      act = {state_o, ball_reset, ball_enable, serve_dir, speed_sel, score1, score2, game_over, winner};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: outputs {st,brst,ben,dir,spd,s1,s2,go,win} got %b expected %b",
                  name, $time, act, exp);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic step(input bit st, input bit tk, input bit g1, input bit g2, input bit hit, input string name);
      start_game = st; frame_tick = tk; goal_p1 = g1; goal_p2 = g2; paddle_hit = hit;
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      check_all(name);
   endtask

   task automatic go_to_play();
      int n = 0;
      while (state_o != 3'd2 && n < 400) begin step(0, 1, 0, 0, 0, "to_play"); n++; end
      check_val("to_play_budget", int'(state_o), 2);
   endtask

   typedef struct {
      int n, st, tk, g1, g2, hit;
      int exp_state, exp_s1, exp_s2, exp_dir;
   } vec_t;
   vec_t tbl[14];

   initial begin
      int cnt;
      logic [2:0] prev;
      tbl = '{
         '{1,   1, 0, 0, 0, 0,  0, 0, 0, 0},
         '{1,   1, 0, 0, 0, 0,  0, 0, 0, 0},
         '{1,   1, 0, 0, 0, 0,  0, 0, 0, 0},
         '{1,   1, 0, 0, 0, 0,  1, 0, 0, 0},
         '{59,  0, 1, 0, 0, 0,  1, 0, 0, 0},
         '{1,   0, 1, 0, 0, 0,  2, 0, 0, 0},
         '{5,   0, 1, 0, 0, 0,  2, 0, 0, 0},
         '{1,   0, 0, 1, 0, 0,  3, 1, 0, 1},
         '{1,   0, 0, 1, 0, 0,  3, 1, 0, 1},
         '{1,   0, 0, 0, 1, 0,  3, 1, 0, 1},
         '{119, 0, 1, 0, 0, 0,  3, 1, 0, 1},
         '{1,   0, 1, 0, 0, 0,  1, 1, 0, 1},
         '{60,  0, 1, 0, 0, 0,  2, 1, 0, 1},
         '{1,   0, 0, 1, 1, 0,  2, 1, 0, 1}
      };

      // reset held low: reset values, speed_sel follows the switch
      #2 reset = 1'b0;
      model_reset();
      for (int s = 0; s < 4; s++) begin
         ball_speed = 2'(s);
         #3;
         check_all("reset_values");
      end
      check_val("reset_state", int'(state_o), 0);
      ball_speed = 2'd0;
      @(negedge clk);
      reset = 1'b1;

      for (int r = 0; r < 14; r++) begin
         for (int k = 0; k < tbl[r].n; k++)
            step(tbl[r].st[0], tbl[r].tk[0], tbl[r].g1[0], tbl[r].g2[0], tbl[r].hit[0], "tbl_step");
         check_val("tbl_state", int'(state_o), tbl[r].exp_state);
         check_val("tbl_score1", int'(score1), tbl[r].exp_s1);
         check_val("tbl_score2", int'(score2), tbl[r].exp_s2);
         check_val("tbl_serve_dir", int'(serve_dir), tbl[r].exp_dir);
      end
      check_val("play_ball_enable", int'(ball_enable), 1);

      // speed ramp: base 2, +1 per 4 hits, saturating at 3, cleared by a goal
      ball_speed = 2'd2;
      step(0, 0, 0, 0, 0, "speed_base");
      check_val("speed_base", int'(speed_sel), 2);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, "hit");
      check_val("speed_3hits", int'(speed_sel), 2);
      step(0, 0, 0, 0, 1, "hit");
      check_val("speed_4hits", int'(speed_sel), 3);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, "hit");
      check_val("speed_8hits", int'(speed_sel), 3);
      step(0, 0, 0, 1, 0, "goal_p2");
      check_val("speed_after_goal", int'(speed_sel), 2);
      check_val("goal_p2_dir", int'(serve_dir), 0);

      // run player 2 up to the winning score
      for (int g = 0; g < 5; g++) begin go_to_play(); step(0, 0, 0, 1, 0, "goal_p2"); end
      check_val("score2_six", int'(score2), 6);
      go_to_play();
      step(0, 0, 0, 1, 0, "winning_goal");
      check_val("win_score2", int'(score2), 7);
      check_val("win_state", int'(state_o), 4);
      check_val("win_winner", int'(winner), 2);
      check_val("win_game_over", int'(game_over), 1);
      step(0, 1, 1, 0, 0, "over_goal");
      check_val("over_frozen_score1", int'(score1), 1);
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, "restart");
      step(0, 0, 0, 0, 0, "restart");
      check_val("restart_state", int'(state_o), 1);
      check_val("restart_scores", int'({score1, score2}), 0);
      check_val("restart_winner", int'(winner), 0);
      check_val("restart_game_over", int'(game_over), 0);

      // reset mid-match drops everything immediately
      go_to_play();
      step(0, 0, 0, 0, 1, "hit");
      step(0, 0, 1, 0, 0, "goal_p1");
      go_to_play();
      step(0, 0, 0, 0, 1, "hit");
      ball_speed = 2'd1;
      reset = 1'b0;
      model_reset();
      #1 check_all("mid_reset");
      check_val("mid_reset_state", int'(state_o), 0);
      check_val("mid_reset_ball_reset", int'(ball_reset), 1);
      step(0, 1, 1, 0, 1, "in_reset");
      @(negedge clk);
      reset = 1'b1;

      // a held start button gives one transition only
      cnt = 0;
      prev = state_o;
      for (int k = 0; k < 1000; k++) begin
         step(1, 0, 0, 0, 0, "held_start");
         if (state_o != prev) cnt++;
         prev = state_o;
      end
      check_val("held_start_transitions", cnt, 1);
      check_val("held_start_state", int'(state_o), 1);
      start_game = 1'b0;

      // random traffic against the model
      for (int k = 0; k < 20000; k++) begin
         bit st;
         st = start_game;
         if ($urandom_range(0, 39) == 0) st = ~st;
         if ($urandom_range(0, 199) == 0) ball_speed = 2'($urandom_range(0, 3));
         step(st, $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 3) == 0, "random");
         if ($urandom_range(0, 7999) == 0) begin
            reset = 1'b0;
            model_reset();
            #1 check_all("random_reset");
            @(negedge clk);
            reset = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
